// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - MSB-first parallel-to-serial shifter with one-word hold register
// Optional macro PARITY_EN appends an even-parity bit to every frame.
module bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);

`ifdef PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int               CNT_W    = $clog2(FRAME);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [FRAME-1:0] r_shift, w_shift_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_hold, w_hold_nxt;
    logic             r_hold_full, w_hold_full_nxt;
    logic             w_xfer;
    logic             w_last;
    logic [FRAME-1:0] w_din_frame;
    logic [FRAME-1:0] w_hold_frame;

    // Frames are built at load time so the shifter only ever moves its MSB out.
`ifdef PARITY_EN
    assign w_din_frame  = {din, ^din};
    assign w_hold_frame = {r_hold, ^r_hold};
`else
    assign w_din_frame  = din;
    assign w_hold_frame = r_hold;
`endif

    assign din_ready = !r_hold_full;
    assign w_xfer    = din_valid && !r_hold_full;
    assign w_last    = (r_state == S_SHIFT) && (r_cnt == '0);

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_shift_nxt = w_din_frame;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt != '0) begin
                    w_shift_nxt = {r_shift[FRAME-2:0], 1'b0};
                    w_cnt_nxt   = r_cnt - 1'b1;
                    if (w_xfer) begin
                        w_hold_nxt      = din;
                        w_hold_full_nxt = 1'b1;
                    end
                end else if (r_hold_full) begin
                    w_shift_nxt     = w_hold_frame;
                    w_cnt_nxt       = CNT_LOAD;
                    w_hold_full_nxt = 1'b0;
                end else if (w_xfer) begin
                    // Bypass the hold register so back-to-back words leave no gap.
                    w_shift_nxt = w_din_frame;
                    w_cnt_nxt   = CNT_LOAD;
                end else begin
                    w_shift_nxt = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
        end
    end

    assign out_valid = (r_state == S_SHIFT);
    assign out_data  = (r_state == S_SHIFT) ? r_shift[FRAME-1] : IDLE_BIT;
    assign out_last  = w_last;
    assign busy      = (r_state == S_SHIFT) || r_hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - randomized and directed bench for bit_serializer against a bit-queue model
module tb_bit_serializer;

`ifdef PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       out_data;
    logic       out_valid;
    logic       out_last;
    logic       busy;

    int   n_total = 0;
    int   n_pass  = 0;
    bit   q[$];
    logic [31:0] seen;
    int   seen_cnt;
    logic xf;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // One clock: compare outputs with the model, drive inputs, advance model past the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r, output logic xfer);
        bit exp_ready;
        bit exp_last;
        exp_ready = (q.size() <= FRAME);
        exp_last  = (q.size() % FRAME) == 1;
        check("out_valid", out_valid, q.size() > 0);
        check("out_data", out_data, (q.size() > 0) ? q[0] : 1'b0);
        check("out_last", out_last, (q.size() > 0) && exp_last);
        check("busy", busy, q.size() > 0);
        check("din_ready", din_ready, exp_ready);
        if (out_valid === 1'b1) begin
            seen = {seen[30:0], out_data};
            seen_cnt++;
        end
        din       = d;
        din_valid = v;
        rst       = r;
        xfer      = v && exp_ready && !r;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (xfer) begin
                for (int i = 7; i >= 0; i--) q.push_back(d[i]);
`ifdef PARITY_EN
                q.push_back(^d);
`endif
            end
        end
    endtask

    task automatic idle_steps(input int n);
        logic x;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, x);
    endtask

    task automatic send_words(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                              input int n);
        logic [7:0] w[3];
        int idx;
        int budget;
        logic x;
        w[0] = w0; w[1] = w1; w[2] = w2;
        idx = 0;
        budget = 200;
        while (idx < n && budget > 0) begin
            step(1'b1, w[idx], 1'b0, x);
            if (x) idx++;
            budget--;
        end
        check("send_timeout", budget > 0, 1'b1);
    endtask

    initial begin
        logic [7:0] rw;
        rst       = 1'b1;
        din       = 8'hFF;
        din_valid = 1'b1;
        seen      = '0;
        seen_cnt  = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: nothing captured even though din_valid was high
        idle_steps(3);

        // Single word, one-cycle valid
        seen = '0; seen_cnt = 0;
        step(1'b1, 8'hB4, 1'b0, xf);
        check("b4_xfer", xf, 1'b1);
        step(1'b0, 8'h00, 1'b0, xf);
        idle_steps(FRAME + 2);
        check("b4_count", seen_cnt, FRAME);
        check("b4_word", (seen >> (FRAME - 8)) & 32'hFF, 32'hB4);

        // Streaming three words back to back
        seen = '0; seen_cnt = 0;
        send_words(8'hFF, 8'h00, 8'hA5, 3);
        idle_steps(3 * FRAME + 3);
        check("stream_count", seen_cnt, 3 * FRAME);

        // Reset while a second word waits in the hold register
        send_words(8'hA5, 8'h3C, 8'h00, 2);
        idle_steps(2);
        step(1'b0, 8'h00, 1'b1, xf);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        idle_steps(FRAME + 2);

`ifdef PARITY_EN
        seen = '0; seen_cnt = 0;
        send_words(8'h07, 8'h03, 8'h00, 2);
        idle_steps(2 * FRAME + 2);
        check("par07", (seen >> 9) & 32'h1FF, 32'h00F);
        check("par03", seen & 32'h1FF, 32'h006);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rw = 8'($urandom);
            step(($urandom_range(0, 9) < 7), rw, ($urandom_range(0, 249) == 0), xf);
        end
        idle_steps(2 * FRAME + 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
